id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Pipeline controller for the instruction-decode stage.
- Resolves read-after-write hazards on the ID operand muxes by generating the forward selects and forward data.
- Detects load-use hazards and data-memory waits, and stalls or bubbles the pipeline accordingly.
- Sequences trap entry: flushes the pipeline, drains older instructions, signals the CSR unit, then waits for its redirect. Also keeps saturating stall and flush counters.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- id_rs1_i, id_rs2_i  in  5  ID source register indices
- id_use_rs1_i, id_use_rs2_i  in  1  ID instruction reads rs1/rs2 through the register path
- id_valid_i  in  1  ID holds a real instruction
- id_illegal_i  in  1  illegal-instruction flag from the decoder
- ex_rd_i  in  5; ex_we_i  in  1; ex_is_ld_i  in  1; ex_dat_i  in  XLEN; ex_exc_i  in  1  EX stage destination/result/exception
- branch_taken_i  in  1  EX resolved a taken branch or jump
- mem_rd_i  in  5; mem_we_i  in  1; mem_dat_i  in  XLEN; mem_valid_i  in  1; mem_exc_i  in  1
- dmem_busy_i  in  1  data memory not ready
- wb_rd_i  in  5; wb_we_i  in  1; wb_dat_i  in  XLEN; wb_valid_i  in  1
- trap_ack_i  in  1  CSR unit has loaded the trap vector
- is_fwd_a_o, is_fwd_b_o  out  1  forward selects for operands A/B
- dat_fwd_a_o, dat_fwd_b_o  out  XLEN  forward data
- stall_if_o, stall_id_o, stall_ex_o, stall_mem_o  out  1  hold stage registers
- flush_if_o, flush_id_o  out  1  invalidate stage registers
- bubble_ex_o  out  1  insert NOP into EX
- trap_o  out  1  one-cycle trap request
- trap_cause_o  out  2  01 = illegal (ID), 10 = EX exception, 11 = MEM exception
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating counters

Behaviour:
- Reset is asynchronous. The state machine goes to RUN, the counters and trap_cause_o clear, and every 1-bit output is 0 while rst_i is high, including the combinational ones.
- Match rule: match(rs, rd, we, use) = use & we & (rd != 0) & (rd == rs). x0 is never forwarded.
- Forward priority per operand is EX > MEM > WB.
  - EX match with ex_is_ld_i = 0: forward ex_dat_i.
  - MEM match: forward mem_dat_i.
  - WB match: forward wb_dat_i.
  - No match: is_fwd = 0 and dat_fwd = 0.
  - Forwarding is combinational, zero latency.
- Load-use: an EX match with ex_is_ld_i = 1 on either used operand. For that cycle assert stall_if_o, stall_id_o and bubble_ex_o. The next cycle the load is in MEM, the MEM forward resolves it, and there is no extra state.
- State machine states: RUN, MEMWAIT, TRAP_DRAIN, TRAP_FIRE, TRAP_WAIT.
- RUN: events are evaluated in priority order.
  1. mem_exc_i, then ex_exc_i, then (id_illegal_i & id_valid_i & !branch_taken_i) → latch the cause, assert flush_if_o, flush_id_o and bubble_ex_o, go to TRAP_DRAIN.
  2. dmem_busy_i → assert all four stalls this cycle, go to MEMWAIT.
  3. branch_taken_i → assert flush_if_o and flush_id_o for one cycle, stay in RUN. A branch overrides a simultaneous load-use stall.
  4. Load-use → stall as above, stay in RUN.
- MEMWAIT:
  - All four stalls stay asserted while dmem_busy_i = 1.
  - When dmem_busy_i = 0, return to RUN with no stall in that cycle.
  - mem_exc_i → go to TRAP_DRAIN with cause 11.
- TRAP_DRAIN:
  - stall_if_o, flush_id_o and bubble_ex_o are held.
  - When mem_valid_i = 0 and wb_valid_i = 0, go to TRAP_FIRE.
  - A MEM exception arriving in this state overwrites the cause to 11.
- TRAP_FIRE: trap_o = 1 for exactly one cycle, then go to TRAP_WAIT.
- TRAP_WAIT:
  - stall_if_o and flush_id_o are held.
  - trap_ack_i → go to RUN.
  - trap_ack_i arriving in TRAP_FIRE is ignored.
- trap_cause_o is held from entry to TRAP_DRAIN until the next trap.
- Counters:
  - stall_cnt_o increments on every cycle with stall_if_o = 1.
  - flush_cnt_o increments on every cycle with flush_id_o = 1.
  - Both saturate at all-ones.
- Forwarding stays active in every state. Stalls caused by traps also count.

Test Plan:
- ADD writes x5 (value 0x10) in EX, ID reads rs1 = 5 → is_fwd_a_o = 1, dat_fwd_a_o = 0x10, no stall.
- x5 matches in both MEM (0xAA) and WB (0xBB) on rs2 → dat_fwd_b_o = 0xAA. With rd = 0 in every stage → is_fwd = 0.
- LW writes x7 in EX, ID uses rs1 = 7 → exactly one cycle of stall_if_o, stall_id_o and bubble_ex_o. The next cycle forwards mem_dat_i. stall_cnt_o increments by 1.
- Load-use plus branch_taken_i in the same cycle → flush_if_o and flush_id_o asserted, no stall, flush_cnt_o increments by 1.
- id_illegal_i with mem_valid_i held at 1 for 3 cycles → TRAP_DRAIN for 3 cycles, then trap_o pulses for one cycle with trap_cause_o = 01. After trap_ack_i, back to RUN.
- dmem_busy_i high for 4 cycles, then mem_exc_i in the 3rd → stalls asserted, then TRAP_DRAIN with cause 11. Assert rst_i mid-drain → outputs 0 immediately, state RUN.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
// Hazard and trap controller for the instruction-decode stage.
//   - Forwards operands from EX, then MEM, then WB (zero latency).
//   - Detects load-use hazards and data-memory waits, and stalls or bubbles.
//   - Sequences trap entry: flush, drain, fire, then wait for the CSR redirect.
//   - Keeps saturating stall and flush counters.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   id_*                              ID source indices, use flags, valid, illegal
//   ex_*, mem_*, wb_*                 destination/result/status of later stages
//   branch_taken_i, dmem_busy_i       redirect and memory-wait inputs
//   trap_ack_i                        CSR unit has loaded the trap vector
//   is_fwd_[ab]_o, dat_fwd_[ab]_o     operand forward selects and data
//   stall_*_o, flush_*_o, bubble_ex_o pipeline control
//   trap_o, trap_cause_o              trap request pulse and latched cause
//   stall_cnt_o, flush_cnt_o          saturating performance counters
// ---------------------------------------------------------------------------
module id_hazard_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_valid_i,
  input  logic             id_illegal_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_we_i,
  input  logic             ex_is_ld_i,
  input  logic [XLEN-1:0]  ex_dat_i,
  input  logic             ex_exc_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_we_i,
  input  logic [XLEN-1:0]  mem_dat_i,
  input  logic             mem_valid_i,
  input  logic             mem_exc_i,
  input  logic             dmem_busy_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_we_i,
  input  logic [XLEN-1:0]  wb_dat_i,
  input  logic             wb_valid_i,
  input  logic             trap_ack_i,
  output logic             is_fwd_a_o,
  output logic             is_fwd_b_o,
  output logic [XLEN-1:0]  dat_fwd_a_o,
  output logic [XLEN-1:0]  dat_fwd_b_o,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             bubble_ex_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0]       CAUSE_ILL = 2'b01;
  localparam logic [1:0]       CAUSE_EX  = 2'b10;
  localparam logic [1:0]       CAUSE_MEM = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_RUN,
    S_MEMWAIT,
    S_TRAP_DRAIN,
    S_TRAP_FIRE,
    S_TRAP_WAIT
  } state_e;

  state_e     state_q, state_n;
  logic [1:0] cause_q, cause_n;

  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b, load_use;
  logic fwd_a, fwd_b;
  logic st_if, st_id, st_ex, st_mem, fl_if, fl_id, bub, trp;

  // A stage matches an operand when it writes a non-zero register the ID instruction reads.
  function automatic logic hit(input logic [4:0] rs, input logic [4:0] rd,
                               input logic we, input logic use_rs);
    return use_rs & we & (rd != 5'd0) & (rd == rs);
  endfunction

  assign ex_a  = hit(id_rs1_i, ex_rd_i,  ex_we_i,  id_use_rs1_i);
  assign ex_b  = hit(id_rs2_i, ex_rd_i,  ex_we_i,  id_use_rs2_i);
  assign mem_a = hit(id_rs1_i, mem_rd_i, mem_we_i, id_use_rs1_i);
  assign mem_b = hit(id_rs2_i, mem_rd_i, mem_we_i, id_use_rs2_i);
  assign wb_a  = hit(id_rs1_i, wb_rd_i,  wb_we_i,  id_use_rs1_i);
  assign wb_b  = hit(id_rs2_i, wb_rd_i,  wb_we_i,  id_use_rs2_i);

  assign load_use = ex_is_ld_i & (ex_a | ex_b);

  // Operand A forward mux; a load in EX shadows older stages since its data is not ready yet.
  always_comb begin
    fwd_a       = 1'b0;
    dat_fwd_a_o = '0;
    if (ex_a) begin
      if (!ex_is_ld_i) begin
        fwd_a       = 1'b1;
        dat_fwd_a_o = ex_dat_i;
      end
    end else if (mem_a) begin
      fwd_a       = 1'b1;
      dat_fwd_a_o = mem_dat_i;
    end else if (wb_a) begin
      fwd_a       = 1'b1;
      dat_fwd_a_o = wb_dat_i;
    end
  end

  // Operand B forward mux, same priority as A.
  always_comb begin
    fwd_b       = 1'b0;
    dat_fwd_b_o = '0;
    if (ex_b) begin
      if (!ex_is_ld_i) begin
        fwd_b       = 1'b1;
        dat_fwd_b_o = ex_dat_i;
      end
    end else if (mem_b) begin
      fwd_b       = 1'b1;
      dat_fwd_b_o = mem_dat_i;
    end else if (wb_b) begin
      fwd_b       = 1'b1;
      dat_fwd_b_o = wb_dat_i;
    end
  end

  // State and cause registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_n;
      cause_q <= cause_n;
    end
  end

  // Next-state and pipeline control.
  always_comb begin
    state_n = state_q;
    cause_n = cause_q;
    st_if   = 1'b0;
    st_id   = 1'b0;
    st_ex   = 1'b0;
    st_mem  = 1'b0;
    fl_if   = 1'b0;
    fl_id   = 1'b0;
    bub     = 1'b0;
    trp     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_exc_i || ex_exc_i || (id_illegal_i && id_valid_i && !branch_taken_i)) begin
          cause_n = mem_exc_i ? CAUSE_MEM : (ex_exc_i ? CAUSE_EX : CAUSE_ILL);
          fl_if   = 1'b1;
          fl_id   = 1'b1;
          bub     = 1'b1;
          state_n = S_TRAP_DRAIN;
        end else if (dmem_busy_i) begin
          st_if   = 1'b1;
          st_id   = 1'b1;
          st_ex   = 1'b1;
          st_mem  = 1'b1;
          state_n = S_MEMWAIT;
        end else if (branch_taken_i) begin
          // The redirect discards the dependent instruction, so no load-use stall.
          fl_if = 1'b1;
          fl_id = 1'b1;
        end else if (load_use) begin
          st_if = 1'b1;
          st_id = 1'b1;
          bub   = 1'b1;
        end
      end
      S_MEMWAIT: begin
        if (mem_exc_i) begin
          cause_n = CAUSE_MEM;
          fl_if   = 1'b1;
          fl_id   = 1'b1;
          bub     = 1'b1;
          state_n = S_TRAP_DRAIN;
        end else if (dmem_busy_i) begin
          st_if  = 1'b1;
          st_id  = 1'b1;
          st_ex  = 1'b1;
          st_mem = 1'b1;
        end else begin
          state_n = S_RUN;
        end
      end
      S_TRAP_DRAIN: begin
        st_if = 1'b1;
        fl_id = 1'b1;
        bub   = 1'b1;
        if (mem_exc_i) cause_n = CAUSE_MEM;
        if (!mem_valid_i && !wb_valid_i) state_n = S_TRAP_FIRE;
      end
      S_TRAP_FIRE: begin
        // Front end stays frozen while the request is issued; an early ack is ignored.
        st_if   = 1'b1;
        fl_id   = 1'b1;
        trp     = 1'b1;
        state_n = S_TRAP_WAIT;
      end
      S_TRAP_WAIT: begin
        st_if = 1'b1;
        fl_id = 1'b1;
        if (trap_ack_i) state_n = S_RUN;
      end
      default: state_n = S_RUN;
    endcase
  end

  // Single-bit outputs are forced low for the whole time reset is asserted.
  assign is_fwd_a_o   = fwd_a  & ~rst_i;
  assign is_fwd_b_o   = fwd_b  & ~rst_i;
  assign stall_if_o   = st_if  & ~rst_i;
  assign stall_id_o   = st_id  & ~rst_i;
  assign stall_ex_o   = st_ex  & ~rst_i;
  assign stall_mem_o  = st_mem & ~rst_i;
  assign flush_if_o   = fl_if  & ~rst_i;
  assign flush_id_o   = fl_id  & ~rst_i;
  assign bubble_ex_o  = bub    & ~rst_i;
  assign trap_o       = trp    & ~rst_i;
  assign trap_cause_o = cause_q;

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_if_o && (stall_cnt_o != CNT_MAX)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_id_o && (flush_cnt_o != CNT_MAX)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_ctrl
// Directed scoreboard bench: the driver applies one vector per cycle and
// queues its hand-computed expectation; the monitor pops and compares on the
// falling edge. Counters run at a narrow width so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_id_hazard_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic             id_use_rs1, id_use_rs2, id_valid, id_illegal;
  logic             ex_we, ex_is_ld, ex_exc, branch_taken;
  logic             mem_we, mem_valid, mem_exc, dmem_busy;
  logic             wb_we, wb_valid, trap_ack;
  logic [XLEN-1:0]  ex_dat, mem_dat, wb_dat;
  logic             is_fwd_a, is_fwd_b, stall_if, stall_id, stall_ex, stall_mem;
  logic             flush_if, flush_id, bubble_ex, trap;
  logic [XLEN-1:0]  dat_fwd_a, dat_fwd_b;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .id_valid_i(id_valid), .id_illegal_i(id_illegal),
    .ex_rd_i(ex_rd), .ex_we_i(ex_we), .ex_is_ld_i(ex_is_ld), .ex_dat_i(ex_dat), .ex_exc_i(ex_exc),
    .branch_taken_i(branch_taken),
    .mem_rd_i(mem_rd), .mem_we_i(mem_we), .mem_dat_i(mem_dat), .mem_valid_i(mem_valid),
    .mem_exc_i(mem_exc), .dmem_busy_i(dmem_busy),
    .wb_rd_i(wb_rd), .wb_we_i(wb_we), .wb_dat_i(wb_dat), .wb_valid_i(wb_valid),
    .trap_ack_i(trap_ack),
    .is_fwd_a_o(is_fwd_a), .is_fwd_b_o(is_fwd_b),
    .dat_fwd_a_o(dat_fwd_a), .dat_fwd_b_o(dat_fwd_b),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex), .stall_mem_o(stall_mem),
    .flush_if_o(flush_if), .flush_id_o(flush_id), .bubble_ex_o(bubble_ex),
    .trap_o(trap), .trap_cause_o(trap_cause),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  typedef struct {
    string            name;
    logic             fa, fb;
    logic [XLEN-1:0]  da, db;
    logic [3:0]       stl;   // {if, id, ex, mem}
    logic             fif, fid, bub, trp;
    logic [1:0]       cause;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  logic             efa, efb;
  logic [XLEN-1:0]  eda, edb;
  logic [1:0]       exp_cause = 2'b00;
  logic [CNT_W-1:0] exp_sc = '0, exp_fc = '0;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h expected=0x%0h", n, f, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "is_fwd_a",   32'(is_fwd_a),   32'(e.fa));
      cmp(e.name, "is_fwd_b",   32'(is_fwd_b),   32'(e.fb));
      cmp(e.name, "dat_fwd_a",  dat_fwd_a,       e.da);
      cmp(e.name, "dat_fwd_b",  dat_fwd_b,       e.db);
      cmp(e.name, "stalls",     32'({stall_if, stall_id, stall_ex, stall_mem}), 32'(e.stl));
      cmp(e.name, "flush_if",   32'(flush_if),   32'(e.fif));
      cmp(e.name, "flush_id",   32'(flush_id),   32'(e.fid));
      cmp(e.name, "bubble_ex",  32'(bubble_ex),  32'(e.bub));
      cmp(e.name, "trap",       32'(trap),       32'(e.trp));
      cmp(e.name, "trap_cause", 32'(trap_cause), 32'(e.cause));
      cmp(e.name, "stall_cnt",  32'(stall_cnt),  32'(e.sc));
      cmp(e.name, "flush_cnt",  32'(flush_cnt),  32'(e.fc));
    end
  end

  // Queue the expectation for the current cycle, then advance the counter model.
  task automatic push(input string n, input logic [3:0] stl,
                      input logic fif, input logic fid, input logic bub, input logic trp);
    exp_t e;
    if (rst) begin
      exp_sc    = '0;
      exp_fc    = '0;
      exp_cause = 2'b00;
    end
    e.name = n; e.fa = efa; e.fb = efb; e.da = eda; e.db = edb;
    e.stl = stl; e.fif = fif; e.fid = fid; e.bub = bub; e.trp = trp;
    e.cause = exp_cause; e.sc = exp_sc; e.fc = exp_fc;
    q.push_back(e);
    if (!rst) begin
      if (stl[3] && exp_sc != CMAX) exp_sc = exp_sc + CNT_W'(1);
      if (fid    && exp_fc != CMAX) exp_fc = exp_fc + CNT_W'(1);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; id_valid = 0; id_illegal = 0;
    ex_rd = '0; ex_we = 0; ex_is_ld = 0; ex_dat = '0; ex_exc = 0; branch_taken = 0;
    mem_rd = '0; mem_we = 0; mem_dat = '0; mem_valid = 0; mem_exc = 0; dmem_busy = 0;
    wb_rd = '0; wb_we = 0; wb_dat = '0; wb_valid = 0; trap_ack = 0;
    efa = 0; efb = 0; eda = '0; edb = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Driver: directed vectors with hand-computed expectations.
  initial begin
    rst = 1'b1;
    idle();
    cyc(); branch_taken = 1; push("rst_branch", 4'b0000, 0, 0, 0, 0);
    cyc(); dmem_busy = 1;    push("rst_busy",   4'b0000, 0, 0, 0, 0);
    cyc(); rst = 1'b0;       push("idle",       4'b0000, 0, 0, 0, 0);

    cyc(); ex_rd = 5; ex_we = 1; ex_dat = 32'h10; id_rs1 = 5; id_use_rs1 = 1;
    efa = 1; eda = 32'h10; push("fwd_ex", 4'b0000, 0, 0, 0, 0);

    cyc(); mem_rd = 5; mem_we = 1; mem_dat = 32'hAA; wb_rd = 5; wb_we = 1; wb_dat = 32'hBB;
    id_rs2 = 5; id_use_rs2 = 1;
    efb = 1; edb = 32'hAA; push("fwd_mem_over_wb", 4'b0000, 0, 0, 0, 0);

    cyc(); wb_rd = 9; wb_we = 1; wb_dat = 32'h1234; id_rs1 = 9; id_use_rs1 = 1;
    efa = 1; eda = 32'h1234; push("fwd_wb", 4'b0000, 0, 0, 0, 0);

    cyc(); ex_we = 1; mem_we = 1; wb_we = 1; ex_dat = 32'h1; mem_dat = 32'h2; wb_dat = 32'h3;
    id_use_rs1 = 1; id_use_rs2 = 1;
    push("fwd_x0", 4'b0000, 0, 0, 0, 0);

    cyc(); ex_rd = 3; ex_we = 1; ex_dat = 32'h33; id_rs1 = 3; id_use_rs1 = 0;
    push("fwd_unused", 4'b0000, 0, 0, 0, 0);

    cyc(); ex_rd = 7; ex_we = 1; ex_is_ld = 1; id_rs1 = 7; id_use_rs1 = 1;
    push("load_use", 4'b1100, 0, 0, 1, 0);

    cyc(); mem_rd = 7; mem_we = 1; mem_dat = 32'h77; id_rs1 = 7; id_use_rs1 = 1;
    efa = 1; eda = 32'h77; push("load_use_resolved", 4'b0000, 0, 0, 0, 0);

    cyc(); ex_rd = 7; ex_we = 1; ex_is_ld = 1; id_rs1 = 7; id_use_rs1 = 1; branch_taken = 1;
    push("branch_over_lu", 4'b0000, 1, 1, 0, 0);

    cyc(); push("idle2", 4'b0000, 0, 0, 0, 0);

    cyc(); id_illegal = 1; id_valid = 1; mem_valid = 1;
    push("trap_enter", 4'b0000, 1, 1, 1, 0);
    exp_cause = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_valid = 1; push("drain", 4'b1000, 0, 1, 1, 0);
    end
    cyc(); push("drain_last", 4'b1000, 0, 1, 1, 0);
    cyc(); trap_ack = 1; push("fire", 4'b1000, 0, 1, 0, 1);
    cyc(); push("wait", 4'b1000, 0, 1, 0, 0);
    cyc(); trap_ack = 1; push("wait_ack", 4'b1000, 0, 1, 0, 0);
    cyc(); push("after_ack", 4'b0000, 0, 0, 0, 0);

    cyc(); dmem_busy = 1; push("busy1", 4'b1111, 0, 0, 0, 0);
    cyc(); dmem_busy = 1; push("busy2", 4'b1111, 0, 0, 0, 0);
    cyc(); dmem_busy = 1; mem_exc = 1; push("busy_exc", 4'b0000, 1, 1, 1, 0);
    exp_cause = 2'b11;
    cyc(); dmem_busy = 1; mem_valid = 1; push("drain_busy", 4'b1000, 0, 1, 1, 0);
    cyc(); mem_valid = 1; push("drain_mid", 4'b1000, 0, 1, 1, 0);
    cyc(); rst = 1'b1; mem_valid = 1; push("rst_mid_drain", 4'b0000, 0, 0, 0, 0);
    cyc(); rst = 1'b0; mem_valid = 1; push("run_after_rst", 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      cyc(); dmem_busy = 1; push("busy_sat", 4'b1111, 0, 0, 0, 0);
    end
    cyc(); push("busy_release", 4'b0000, 0, 0, 0, 0);
    cyc(); push("final_idle", 4'b0000, 0, 0, 0, 0);

    cyc();
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  // End of run, or bounded abort if the driver or queue never drains.
  initial begin
    int cycles;
    cycles = 0;
    while (!(done && q.size() == 0) && cycles < 2000) begin
      @(posedge clk);
      cycles++;
    end
    if (cycles >= 2000) begin
      failures++;
      $display("FAIL timeout actual=%0d cycles expected=<2000 pending=%0d", cycles, q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
